// File: rtl/poly_horner_eval.sv
// Sequential Horner-scheme polynomial evaluator: the operator strobes in the
// coefficients (highest first) and then x, and one multiply-accumulate runs per cycle.
module poly_horner_eval #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_result,
  output logic             done,
  output logic             busy,
  output logic [3:0]       load_idx
);

  localparam int         NUM_OPS  = DEGREE + 2;
  localparam logic [3:0] LAST_IDX = 4'(DEGREE + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_LOAD_WAIT,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       loadIdx_q, loadIdx_d;
  logic [3:0]       step_q, step_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] ops_q [NUM_OPS];
  logic [WIDTH-1:0] ops_d [NUM_OPS];

  logic [3:0]       coefIdx;
  logic [WIDTH-1:0] coef;
  logic [WIDTH-1:0] xVal;
  logic [WIDTH-1:0] macOut;

  // Slot 0 holds c[DEGREE] and slot DEGREE+1 holds x, so c[k-1] lives in slot DEGREE-k+1.
  always_comb begin
    coefIdx = 4'(DEGREE) - step_q + 4'd1;
    coef    = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (coefIdx == 4'(i)) coef = ops_q[i];
    end
    xVal   = ops_q[NUM_OPS-1];
    macOut = acc_q * xVal + coef;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_LOAD;
      loadIdx_q <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      loadIdx_q <= loadIdx_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      ops_q     <= ops_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    loadIdx_d = loadIdx_q;
    step_d    = step_q;
    acc_d     = acc_q;
    result_d  = result_q;
    ops_d     = ops_q;

    case (state_q)
      S_LOAD: begin
        if (go) begin
          for (int i = 0; i < NUM_OPS; i++) begin
            if (loadIdx_q == 4'(i)) ops_d[i] = data_in;
          end
          state_d = S_LOAD_WAIT;
        end
      end
      // Advancing only once go falls makes a long strobe count as a single capture.
      S_LOAD_WAIT: begin
        if (!go) begin
          if (loadIdx_q < LAST_IDX) begin
            loadIdx_d = loadIdx_q + 4'd1;
            state_d   = S_LOAD;
          end else begin
            loadIdx_d = '0;
            step_d    = 4'(DEGREE);
            acc_d     = ops_q[0];
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d  = macOut;
        step_d = step_q - 4'd1;
        if (step_q == 4'd1) begin
          result_d = macOut;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        loadIdx_d = '0;
        state_d   = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign data_result = result_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
  assign load_idx    = loadIdx_q;

endmodule
